// File: rtl/tluh_pkg.sv
// Shared TL-UH widths, opcodes and channel payloads used by the host adapter.
package tluh_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 3;
  localparam int unsigned TL_AIW = 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tluh_a_m_op;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2
  } tluh_d_m_op;

  typedef struct packed {
    logic                a_valid;
    tluh_a_m_op          a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tluh_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tluh_d_m_op          d_opcode;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tluh_d2h_t;

  // D opcode a well-behaved device answers with for a given A opcode.
  function automatic tluh_d_m_op exp_d_op(input tluh_a_m_op op);
    case (op)
      Get, ArithmeticData, LogicalData: return AccessAckData;
      Intent:                           return HintAck;
      default:                          return AccessAck;
    endcase
  endfunction

endpackage

// File: rtl/tluh_host_adapter_if.sv
// TL-UH link bundle between a host adapter and a device.
interface tluh_host_adapter_if;
  import tluh_pkg::*;

  tluh_h2d_t h2d;
  tluh_d2h_t d2h;

  modport host   (output h2d, input  d2h);
  modport device (input  h2d, output d2h);
endinterface

// File: rtl/tluh_host_adapter.sv
// Single-outstanding local-request to TL-UH host bridge with local error
// screening, multi-beat Get responses, response checking and D timeout.
module tluh_host_adapter
  import tluh_pkg::*;
#(
  parameter int unsigned SourceBase    = 0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  tluh_a_m_op        opcode_i,
  input  logic [2:0]        param_i,
  input  logic [TL_SZW-1:0] size_i,
  input  logic [TL_AW-1:0]  addr_i,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] be_i,
  output logic              rvalid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              rlast_o,
  output logic              err_o,
  output tluh_h2d_t         tl_o,
  input  tluh_d2h_t         tl_i
);

  localparam int unsigned TW      = $clog2(TimeoutCycles + 1);
  localparam int unsigned BEAT_LG = $clog2(TL_DBW);
  localparam int unsigned MAX_LG  = BEAT_LG + 2;

  typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT} state_e;

  state_e           r_state,  w_state_n;
  tluh_h2d_t        r_h2d,    w_h2d_n;
  logic [1:0]       r_tag,    w_tag_n;
  logic [1:0]       r_beats,  w_beats_n;
  logic [TW-1:0]    r_tmo,    w_tmo_n;
  logic             r_gnt,    w_gnt_n;
  logic             r_rvalid, w_rvalid_n;
  logic             r_rlast,  w_rlast_n;
  logic             r_err,    w_err_n;
  logic [TL_DW-1:0] r_rdata,  w_rdata_n;

  logic             w_req_ack, w_a_ack, w_d_ack, w_lerr, w_lerr_now, w_tmo_hit;
  logic [1:0]       w_tag_inc, w_beats_req;
  logic [TL_AW-1:0] w_align_mask;
  tluh_d_m_op       w_exp_op;

  assign w_req_ack    = req_i & r_gnt;
  assign w_a_ack      = r_h2d.a_valid & tl_i.a_ready;
  assign w_d_ack      = r_h2d.d_ready & tl_i.d_valid;
  assign w_tag_inc    = r_tag + 2'd1;
  assign w_exp_op     = exp_d_op(r_h2d.a_opcode);
  assign w_tmo_hit    = (r_tmo == TW'(TimeoutCycles - 1));
  assign w_align_mask = (TL_AW'(1) << size_i) - TL_AW'(1);

  // Oversized, misaligned, or multi-beat non-Get requests never reach the bus.
  assign w_lerr = (size_i > TL_SZW'(MAX_LG)) || (|(addr_i & w_align_mask)) ||
                  ((opcode_i != Get) && (size_i > TL_SZW'(BEAT_LG)));

  // Remaining beats after the first, as loaded into the down-counter.
  assign w_beats_req = ((opcode_i == Get) && (size_i > TL_SZW'(BEAT_LG))) ?
                       2'((3'd1 << (size_i - TL_SZW'(BEAT_LG))) - 3'd1) : 2'd0;

  always_comb begin
    w_state_n  = r_state;
    w_h2d_n    = r_h2d;
    w_tag_n    = r_tag;
    w_beats_n  = r_beats;
    w_tmo_n    = r_tmo;
    w_rvalid_n = 1'b0;
    w_rlast_n  = 1'b0;
    w_err_n    = 1'b0;
    w_rdata_n  = '0;
    w_lerr_now = 1'b0;

    case (r_state)
      IDLE: begin
        w_h2d_n.d_ready = 1'b1;
        if (w_req_ack) begin
          if (w_lerr) begin
            w_lerr_now = 1'b1;
            w_rvalid_n = 1'b1;
            w_rlast_n  = 1'b1;
            w_err_n    = 1'b1;
            w_rdata_n  = '1;
          end else begin
            w_state_n         = A_REQ;
            w_tag_n           = w_tag_inc;
            w_beats_n         = w_beats_req;
            w_h2d_n.a_valid   = 1'b1;
            w_h2d_n.a_opcode  = opcode_i;
            w_h2d_n.a_param   = param_i;
            w_h2d_n.a_size    = size_i;
            w_h2d_n.a_source  = {(TL_AIW-2)'(SourceBase), w_tag_inc};
            w_h2d_n.a_address = addr_i;
            w_h2d_n.a_mask    = be_i;
            w_h2d_n.a_data    = wdata_i;
            w_h2d_n.d_ready   = 1'b0;
          end
        end
      end
      A_REQ: begin
        if (w_a_ack) begin
          w_state_n       = D_WAIT;
          w_h2d_n.a_valid = 1'b0;
          w_h2d_n.d_ready = 1'b1;
          w_tmo_n         = '0;
        end
      end
      D_WAIT: begin
        if (w_d_ack) begin
          w_tmo_n    = '0;
          w_rvalid_n = 1'b1;
          w_rlast_n  = (r_beats == 2'd0);
          w_rdata_n  = (w_exp_op == AccessAckData) ? tl_i.d_data : '0;
          w_err_n    = tl_i.d_error || (tl_i.d_opcode != w_exp_op) ||
                       (tl_i.d_source != r_h2d.a_source);
          if (r_beats == 2'd0) w_state_n = IDLE;
          else                 w_beats_n = r_beats - 2'd1;
        end else if (w_tmo_hit) begin
          w_tmo_n    = '0;
          w_rvalid_n = 1'b1;
          w_rlast_n  = 1'b1;
          w_err_n    = 1'b1;
          w_rdata_n  = '1;
          w_beats_n  = 2'd0;
          w_state_n  = IDLE;
        end else begin
          w_tmo_n = r_tmo + TW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase

    // Grant only from a settled IDLE; withheld during a local-error pulse.
    w_gnt_n = (w_state_n == IDLE) && !w_lerr_now;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_h2d    <= '0;
      r_tag    <= '0;
      r_beats  <= '0;
      r_tmo    <= '0;
      r_gnt    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_h2d    <= w_h2d_n;
      r_tag    <= w_tag_n;
      r_beats  <= w_beats_n;
      r_tmo    <= w_tmo_n;
      r_gnt    <= w_gnt_n;
      r_rvalid <= w_rvalid_n;
      r_rlast  <= w_rlast_n;
      r_err    <= w_err_n;
      r_rdata  <= w_rdata_n;
    end
  end

  assign gnt_o    = r_gnt;
  assign rvalid_o = r_rvalid;
  assign rlast_o  = r_rlast;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;
  assign tl_o     = r_h2d;

endmodule

// File: tb/tb_tluh_host_adapter.sv
// Directed bench for tluh_host_adapter: reset, Get, burst Get, stalled Put,
// local and response errors, D timeout, and reset mid-transaction.
module tb_tluh_host_adapter;
  import tluh_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  tluh_a_m_op        opcode = Get;
  logic [2:0]        param = 3'd0;
  logic [TL_SZW-1:0] size = '0;
  logic [TL_AW-1:0]  addr = '0;
  logic [TL_DW-1:0]  wdata = '0;
  logic [TL_DBW-1:0] be = '1;
  logic              gnt, rvalid, rlast, err;
  logic [TL_DW-1:0]  rdata;

  int n_tests = 0;
  int n_fail  = 0;

  tluh_host_adapter_if bus ();

  tluh_host_adapter #(.SourceBase(5), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
    .opcode_i(opcode), .param_i(param), .size_i(size), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata),
    .rlast_o(rlast), .err_o(err), .tl_o(bus.h2d), .tl_i(bus.d2h)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input tluh_a_m_op op, input logic [TL_SZW-1:0] sz,
                       input logic [TL_AW-1:0] ad, input logic [TL_DW-1:0] wd);
    opcode = op; size = sz; addr = ad; wdata = wd; req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic dbeat(input tluh_d_m_op op, input logic [TL_AIW-1:0] src,
                       input logic [TL_DW-1:0] data, input logic derr);
    bus.d2h.d_valid  = 1'b1;
    bus.d2h.d_opcode = op;
    bus.d2h.d_source = src;
    bus.d2h.d_data   = data;
    bus.d2h.d_error  = derr;
    step();
    bus.d2h.d_valid  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    bus.d2h = '0;
    bus.d2h.a_ready = 1'b1;

    // reset values
    step(); step(); step();
    chk("rst_gnt", gnt, 0);
    chk("rst_outs", {rvalid, rlast, err, rdata}, 0);
    chk("rst_tl", {bus.h2d.a_valid, bus.h2d.d_ready}, 0);
    rst = 1'b0;
    step();
    chk("first_gnt", {gnt, bus.h2d.d_ready}, 2'b11);

    // single-beat Get, tag 1
    be = 4'hF;
    issue(Get, 3'd2, 32'h10, 32'h0);
    chk("get_a_valid", bus.h2d.a_valid, 1);
    chk("get_a_src", bus.h2d.a_source, 8'h15);
    chk("get_a_addr", {bus.h2d.a_opcode, bus.h2d.a_size, bus.h2d.a_address}, {Get, 3'd2, 32'h10});
    chk("get_gnt_busy", gnt, 0);
    step();
    chk("get_a_drop", bus.h2d.a_valid, 0);
    dbeat(AccessAckData, 8'h15, 32'hDEADBEEF, 1'b0);
    chk("get_resp", {rvalid, rlast, err, rdata}, {3'b110, 32'hDEADBEEF});
    chk("get_gnt_back", gnt, 1);
    step();
    chk("get_pulse_end", rvalid, 0);

    // 4-beat Get, tag 2
    issue(Get, 3'd4, 32'h20, 32'h0);
    chk("burst_src", bus.h2d.a_source, 8'h16);
    step();
    for (int i = 1; i <= 4; i++) begin
      bus.d2h.d_valid  = 1'b1;
      bus.d2h.d_opcode = AccessAckData;
      bus.d2h.d_source = 8'h16;
      bus.d2h.d_data   = 32'(i);
      bus.d2h.d_error  = 1'b0;
      step();
      chk("burst_beat", {rvalid, rlast, err, rdata}, {1'b1, (i == 4), 1'b0, 32'(i)});
    end
    bus.d2h.d_valid = 1'b0;
    chk("burst_gnt", gnt, 1);

    // PutFullData with a_ready low for 5 cycles, tag 3
    bus.d2h.a_ready = 1'b0;
    issue(PutFullData, 3'd2, 32'h8, 32'h12345678);
    for (int k = 0; k < 6; k++) begin
      chk("put_hold", {bus.h2d.a_valid, bus.h2d.a_opcode, bus.h2d.a_source,
                       bus.h2d.a_address, bus.h2d.a_mask, bus.h2d.a_data},
          {1'b1, PutFullData, 8'h17, 32'h8, 4'hF, 32'h12345678});
      if (k == 5) bus.d2h.a_ready = 1'b1;
      step();
    end
    chk("put_a_drop", bus.h2d.a_valid, 0);
    dbeat(AccessAck, 8'h17, 32'hCAFEF00D, 1'b0);
    chk("put_resp", {rvalid, rlast, err, rdata}, {3'b110, 32'h0});

    // local error: misaligned Get
    issue(Get, 3'd2, 32'h2, 32'h0);
    chk("lerr_resp", {rvalid, rlast, err, rdata}, {3'b111, 32'hFFFFFFFF});
    chk("lerr_no_a", {bus.h2d.a_valid, gnt}, 2'b00);
    step();
    chk("lerr_gnt_back", {gnt, rvalid}, 2'b10);

    // local error: Put wider than one beat
    issue(PutFullData, 3'd3, 32'h0, 32'h0);
    chk("lerr_put_wide", {rvalid, err, bus.h2d.a_valid}, 3'b110);
    step();

    // wrong d_source, tag wraps to 0
    issue(Get, 3'd2, 32'h30, 32'h0);
    chk("wrap_src", bus.h2d.a_source, 8'h14);
    step();
    dbeat(AccessAckData, 8'h15, 32'h55, 1'b0);
    chk("bad_src_err", {rvalid, rlast, err}, 3'b111);

    // timeout, tag 1
    issue(Get, 3'd2, 32'h40, 32'h0);
    step();
    quiet = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (rvalid) quiet++;
    end
    chk("tmo_early", quiet, 0);
    step();
    chk("tmo_pulse", {rvalid, rlast, err, rdata}, {3'b111, 32'hFFFFFFFF});
    chk("tmo_gnt", gnt, 1);
    dbeat(AccessAckData, 8'h15, 32'h77, 1'b0);
    chk("tmo_late_drop", rvalid, 0);

    // reset in D_WAIT, tag 2 abandoned
    issue(Get, 3'd2, 32'h50, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_outs", {gnt, rvalid, rlast, err, rdata}, 0);
    chk("mid_rst_tl", {bus.h2d.a_valid, bus.h2d.d_ready}, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_gnt", gnt, 1);
    dbeat(AccessAckData, 8'h16, 32'h99, 1'b0);
    chk("post_rst_drop", rvalid, 0);
    issue(Get, 3'd2, 32'h60, 32'h0);
    chk("post_rst_tag", bus.h2d.a_source, 8'h15);
    step();
    dbeat(AccessAckData, 8'h15, 32'hA5A5A5A5, 1'b0);
    chk("post_rst_resp", {rvalid, rlast, err, rdata}, {3'b110, 32'hA5A5A5A5});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tluh_host_adapter.md
TLUH_HOST_ADAPTER -- requirements
Module: tluh_host_adapter

Interface
REQ-001 Parameter SourceBase, default 0: the upper a_source bits are fixed to SourceBase; the lowest 2 bits carry the rolling tag.
REQ-002 Parameter TimeoutCycles, default 1024: maximum number of cycles spent in D_WAIT without a D beat.
REQ-003 clk_i  in  1  single clock; all logic changes on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 req_i  in  1  local request valid.
REQ-006 gnt_o  out  1  request accepted; the request transfers when req_i & gnt_o.
REQ-007 opcode_i  in  tluh_a_m_op  Get, PutFullData, PutPartialData, ArithmeticData, LogicalData or Intent.
REQ-008 param_i  in  3  a_param: atomic function or intent.
REQ-009 size_i  in  SZW  log2 of the transfer size in bytes.
REQ-010 addr_i  in  TL_AW  byte address.
REQ-011 wdata_i  in  TL_DW  write or atomic operand.
REQ-012 be_i  in  TL_DBW  byte mask.
REQ-013 rvalid_o  out  1  one-cycle pulse per response beat.
REQ-014 rdata_o  out  TL_DW  response data.
REQ-015 rlast_o  out  1  marks the final beat of a transaction.
REQ-016 err_o  out  1  error flag, qualified by rvalid_o.
REQ-017 tl_o  out  tluh_h2d_t  TL-UH A channel plus d_ready.
REQ-018 tl_i  in  tluh_d2h_t  TL-UH D channel plus a_ready.

Function
REQ-019 The FSM shall have three states: IDLE, A_REQ and D_WAIT. It shall allow one outstanding transaction only.
REQ-020 IDLE shall behave as follows:
- gnt_o=1 and d_ready=1; any stray D beat is accepted and dropped with no rvalid_o.
- On a request, all request fields are registered, the tag increments modulo 4, and the FSM moves to A_REQ.
REQ-021 A local error shall be raised in place of any TL traffic if size_i > log2(4*TL_DBW), or if addr_i is misaligned to 2^size_i.
- The block stays in IDLE and pulses rvalid_o=1, err_o=1, rlast_o=1, rdata_o='1 in the next cycle.
- gnt_o=0 in that cycle.
REQ-022 A_REQ shall behave as follows:
- a_valid=1, driven from the registered fields with a_source={SourceBase,tag}.
- The fields are held stable until a_ready.
- On a_ack the FSM moves to D_WAIT; a_valid=0 from the next cycle.
REQ-023 Puts and atomics shall be single-beat. A request with opcode != Get and size_i > log2(TL_DBW) shall take the REQ-021 local error path.
REQ-024 In D_WAIT, d_ready shall be 1. Every d_ack shall produce rvalid_o in the next cycle, with rdata_o = registered d_data.
REQ-025 The expected beat count shall be 2^size/TL_DBW for a Get with size > log2(TL_DBW), and 1 otherwise.
- A 2-bit beat counter counts down; rlast_o=1 on the last beat; the FSM returns to IDLE after the last d_ack.
REQ-026 The expected d_opcode shall be:
- AccessAckData for Get, ArithmeticData and LogicalData;
- AccessAck for Puts;
- HintAck for Intent.
REQ-027 For a write or intent response, rdata_o shall be 0.
REQ-028 err_o shall equal d_error | (d_opcode mismatch) | (d_source != issued source) for each beat. An erroneous beat still counts toward the beat count.
REQ-029 A D beat whose source matches a stale tag shall not be reported if it arrives after a timeout.
REQ-030 The timeout counter shall clear on entry to D_WAIT and on each d_ack.
- When it reaches TimeoutCycles, the block pulses rvalid_o=1, err_o=1, rlast_o=1, rdata_o='1 and goes to IDLE.
REQ-031 d_ack and a new req_i in the same cycle as the final beat shall not be granted. gnt_o reasserts in IDLE on the following cycle.

Reset
REQ-032 While rst_i=1, the block shall hold the following values, and the first grant may occur on the first cycle after rst_i deasserts:
- FSM in IDLE;
- a_valid=0, d_ready=0, gnt_o=0;
- rvalid_o=0, rlast_o=0, err_o=0, rdata_o=0;
- tag=0, beat counter=0, timeout counter=0.
REQ-033 Reset mid-transaction shall abandon the transaction without a response pulse. Any later D beat is dropped in IDLE.

Structure
REQ-034 tluh_pkg shall hold tluh_h2d_t, tluh_d2h_t, tluh_a_m_op, tluh_d_m_op, TL_AW, TL_DW and TL_DBW. No new package types are added.
REQ-035 tluh_host_adapter shall be the only module; no sub-module is required.

Verification
REQ-036 Get: size=2, addr=0x10, a_ready=1; D returns AccessAckData with data 0xDEADBEEF -> one rvalid_o with rdata_o=0xDEADBEEF, rlast_o=1, err_o=0.
REQ-037 Burst Get: size=4, addr=0x20 -> four D beats 1,2,3,4 give four rvalid_o pulses with rlast_o only on the 4th, then gnt_o=1.
REQ-038 PutFullData: addr=0x8, be=0xF; a_ready held low 5 cycles -> A fields stable for 6 cycles; AccessAck -> rdata_o=0, err_o=0.
REQ-039 Errors:
- Get with addr=0x2, size=2 -> no a_valid, err_o=1, rdata_o=0xFFFFFFFF.
- A D beat with the wrong d_source -> err_o=1.
REQ-040 Timeout: TimeoutCycles=8 and no D beat -> err_o pulse exactly 8 cycles after entry to D_WAIT; a late D beat after that is dropped silently.
REQ-041 rst_i asserted in D_WAIT -> all outputs at their reset values, no rvalid_o; the next request uses tag 1.
